// File: rtl/ntt_sampler_feeder_if.sv
// Sampler-to-NTT stream bundle: sampler push side plus the pwm_b read request/response side.
// master = sampler/ntt_top environment, slave = ntt_sampler_feeder.
interface ntt_sampler_feeder_if #(
  parameter int DATA_WIDTH     = 96,
  parameter int MEM_ADDR_WIDTH = 14
);
  logic                      smp_valid_i;
  logic [DATA_WIDTH-1:0]     smp_data_i;
  logic                      smp_ready_o;
  logic                      pwm_b_rd_en_i;
  logic [MEM_ADDR_WIDTH-1:0] pwm_b_rd_addr_i;
  logic                      sampler_valid_o;
  logic [DATA_WIDTH-1:0]     sampler_data_o;

  modport master (
    output smp_valid_i, smp_data_i, pwm_b_rd_en_i, pwm_b_rd_addr_i,
    input  smp_ready_o, sampler_valid_o, sampler_data_o
  );

  modport slave (
    input  smp_valid_i, smp_data_i, pwm_b_rd_en_i, pwm_b_rd_addr_i,
    output smp_ready_o, sampler_valid_o, sampler_data_o
  );
endinterface

// File: rtl/ntt_sampler_feeder.sv
// Small FIFO that feeds sampler words to the NTT pwm_b read port, one polynomial per start.
// Optional read-address sequence check enabled by defining NTT_SMP_ADDR_CHECK_EN.
module ntt_sampler_feeder #(
  parameter int DATA_WIDTH     = 96,
  parameter int DEPTH          = 4,
  parameter int MEM_ADDR_WIDTH = 14,
  parameter int MLDSA_N        = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      zeroize,
  input  logic                      start_i,
  input  logic [MEM_ADDR_WIDTH-1:0] base_addr_i,
  ntt_sampler_feeder_if.slave       bus,
  output logic                      done_o,
  output logic                      underflow_o,
  output logic                      addr_err_o
);
  localparam int WORDS = MLDSA_N / 4;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int POP_W = $clog2(WORDS + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [POP_W-1:0] LAST = POP_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [POP_W-1:0]      pop_cnt;
  logic [DATA_WIDTH-1:0] rd_data_p1;
  logic                  clr;
  logic                  streaming;
  logic                  ready;
  logic                  push;
  logic                  pop;
  logic                  empty_rd;

  assign clr       = reset | zeroize;
  assign streaming = (state == STREAM);
  assign ready     = streaming && (count != FULL);
  assign push      = bus.smp_valid_i & ready;
  assign pop       = bus.pwm_b_rd_en_i & streaming & (count != '0);
  assign empty_rd  = bus.pwm_b_rd_en_i & streaming & (count == '0);

  assign bus.smp_ready_o     = ready;
  assign bus.sampler_valid_o = streaming && (count != '0);
  assign bus.sampler_data_o  = rd_data_p1;

  always_ff @(posedge clk) begin
    if (zeroize) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= bus.smp_data_i;
    end
  end

  // Read stage: head word lands in rd_data_p1 one cycle after the accepted rd_en
  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      pop_cnt     <= '0;
      rd_data_p1  <= '0;
      done_o      <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        rd_data_p1 <= mem[rd_ptr];
        pop_cnt    <= pop_cnt + POP_W'(1);
      end
      if (empty_rd) begin
        rd_data_p1  <= '0;
        underflow_o <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      case (state)
        IDLE: begin
          if (start_i) begin
            state       <= STREAM;
            pop_cnt     <= '0;
            underflow_o <= 1'b0;
          end
        end
        STREAM: begin
          if (pop && (pop_cnt == LAST)) begin
            state  <= DONE;
            done_o <= 1'b1;
          end
        end
        DONE: begin
          // Leftover words belong to no polynomial; drop them
          state  <= IDLE;
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NTT_SMP_ADDR_CHECK_EN
  logic [MEM_ADDR_WIDTH-1:0] exp_addr;

  always_ff @(posedge clk) begin
    if (clr) begin
      exp_addr   <= '0;
      addr_err_o <= 1'b0;
    end else if ((state == IDLE) && start_i) begin
      exp_addr   <= base_addr_i;
      addr_err_o <= 1'b0;
    end else if (pop) begin
      exp_addr <= exp_addr + MEM_ADDR_WIDTH'(1);
      if (bus.pwm_b_rd_addr_i != exp_addr) addr_err_o <= 1'b1;
    end
  end
`else
  logic unused_addr;
  assign unused_addr = ^{bus.pwm_b_rd_addr_i, base_addr_i};
  assign addr_err_o  = 1'b0;
`endif
endmodule

// File: tb/tb_ntt_sampler_feeder.sv
// Scoreboard bench for ntt_sampler_feeder: queue of pushed words popped against read data.
module tb_ntt_sampler_feeder;
  localparam int DW    = 96;
  localparam int DEPTH = 4;
  localparam int AW    = 14;
  localparam int N     = 256;
  localparam int WORDS = N / 4;
`ifdef NTT_SMP_ADDR_CHECK_EN
  localparam bit EXP_ERR = 1'b1;
`else
  localparam bit EXP_ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          zeroize;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic          done_o;
  logic          underflow_o;
  logic          addr_err_o;

  ntt_sampler_feeder_if #(.DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW)) bus ();

  ntt_sampler_feeder #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .MEM_ADDR_WIDTH(AW), .MLDSA_N(N)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .zeroize     (zeroize),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .bus         (bus),
    .done_o      (done_o),
    .underflow_o (underflow_o),
    .addr_err_o  (addr_err_o)
  );

  always #5 clk = ~clk;

  // Reference state: 0 idle, 1 stream, 2 done
  int            m_state;
  logic [DW-1:0] m_q[$];
  int            m_pop_cnt;
  logic [DW-1:0] m_data;
  bit            m_uf;
  bit            m_err;
  bit            m_done;
  logic [AW-1:0] m_exp;
  logic [AW-1:0] base;
  int            salt;
  int            k;
  int            n_done;
  int            n_chk = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] word(input int idx);
    if (salt == 0) return DW'(idx);
    return {32'(idx * salt) ^ 32'hDEAD_BEEF, 32'(idx), 32'(salt)};
  endfunction

  task automatic cyc(input bit rst, input bit zer, input bit st, input bit v,
                     input logic [DW-1:0] d, input bit rd, input logic [AW-1:0] a);
    bit rdy, push, pop, uf;
    reset               = rst;
    zeroize             = zer;
    start_i             = st;
    base_addr_i         = base;
    bus.smp_valid_i     = v;
    bus.smp_data_i      = d;
    bus.pwm_b_rd_en_i   = rd;
    bus.pwm_b_rd_addr_i = a;
    rdy  = (m_state == 1) && (m_q.size() < DEPTH);
    push = v && rdy;
    pop  = rd && (m_state == 1) && (m_q.size() > 0);
    uf   = rd && (m_state == 1) && (m_q.size() == 0);
    @(posedge clk);
    #1;
    if (rst || zer) begin
      m_state = 0; m_q.delete(); m_data = '0; m_uf = 0; m_err = 0; m_done = 0; m_pop_cnt = 0;
    end else begin
      m_done = 0;
      if (pop) begin
        m_data = m_q.pop_front();
`ifdef NTT_SMP_ADDR_CHECK_EN
        if (a !== m_exp) m_err = 1;
`endif
        m_exp = m_exp + 1'b1;
      end
      if (uf) begin
        m_data = '0;
        m_uf   = 1;
      end
      if (push) m_q.push_back(d);
      case (m_state)
        0: if (st) begin
          m_state = 1; m_pop_cnt = 0; m_exp = base; m_uf = 0; m_err = 0;
        end
        1: if (pop) begin
          if (m_pop_cnt == WORDS - 1) begin
            m_state = 2;
            m_done  = 1;
          end
          m_pop_cnt++;
        end
        default: begin
          m_state = 0;
          m_q.delete();
        end
      endcase
    end
    if (done_o === 1'b1) n_done++;
    chk("data",      bus.sampler_data_o,  m_data);
    chk("done",      done_o,              m_done);
    chk("underflow", underflow_o,         m_uf);
    chk("addr_err",  addr_err_o,          m_err);
    chk("ready",     bus.smp_ready_o,     (m_state == 1) && (m_q.size() < DEPTH));
    chk("valid",     bus.sampler_valid_o, (m_state == 1) && (m_q.size() > 0));
  endtask

  // rd_mode: 0 never, 1 every cycle, 2 whenever the reference FIFO holds a word
  task automatic drive(input int n, input bit v_on, input int rd_mode);
    bit rdy, rd;
    for (int c = 0; c < n; c++) begin
      rdy = (m_state == 1) && (m_q.size() < DEPTH);
      rd  = (rd_mode == 1) || ((rd_mode == 2) && (m_q.size() > 0));
      cyc(0, 0, 0, v_on, word(k), rd, m_exp);
      if (v_on && rdy) k++;
    end
  endtask

  task automatic stream_poly(input logic [AW-1:0] b, input int s);
    int d0;
    salt = s;
    base = b;
    k    = 0;
    d0   = n_done;
    cyc(0, 0, 1, 0, '0, 0, '0);
    for (int c = 0; c < 300 && m_state != 0; c++) drive(1, k < WORDS, 2);
    chk("done_once", n_done - d0, 1);
    chk("uf_clean",  underflow_o, 0);
  endtask

  initial begin
    reset = 1'b1; zeroize = 1'b0; start_i = 1'b0; base_addr_i = '0;
    bus.smp_valid_i = 1'b0; bus.smp_data_i = '0;
    bus.pwm_b_rd_en_i = 1'b0; bus.pwm_b_rd_addr_i = '0;
    m_state = 0; m_pop_cnt = 0; m_data = '0; m_uf = 0; m_err = 0; m_done = 0;
    m_exp = '0; base = '0; salt = 0; k = 0; n_done = 0;

    cyc(1, 0, 0, 0, '0, 0, '0);
    cyc(0, 0, 0, 0, '0, 1, '0);

    // Full-rate polynomial of words 0..63
    stream_poly(14'h0000, 0);

    // Fill to DEPTH with no reads, then one read frees a slot
    salt = 1; base = 14'h0010; k = 0;
    cyc(0, 0, 1, 0, '0, 0, '0);
    drive(6, 1, 0);
    chk("full_ready", bus.smp_ready_o, 0);
    drive(1, 1, 1);
    chk("ready_back", bus.smp_ready_o, 1);
    drive(1, 1, 0);
    for (int c = 0; c < 10 && m_q.size() > 0; c++) drive(1, 0, 2);
    drive(1, 0, 1);
    chk("uf_data", bus.sampler_data_o, 0);
    chk("uf_flag", underflow_o, 1);
    drive(1, 0, 0);
    cyc(1, 0, 0, 0, '0, 0, '0);

    // Reset after five pops, then a clean polynomial
    salt = 3; base = 14'h0020; k = 0;
    cyc(0, 0, 1, 0, '0, 0, '0);
    for (int c = 0; c < 50 && m_pop_cnt < 5; c++) drive(1, k < 10, 2);
    cyc(1, 0, 0, 0, '0, 0, '0);
    chk("rst_data", bus.sampler_data_o, 0);
    stream_poly(14'h0100, 5);

    // Address sequence 0x40, 0x41, 0x43
    salt = 7; base = 14'h0040; k = 0;
    cyc(0, 0, 1, 0, '0, 0, '0);
    drive(3, 1, 0);
    cyc(0, 0, 0, 0, '0, 1, 14'h0040);
    cyc(0, 0, 0, 0, '0, 1, 14'h0041);
    chk("addr_ok_2nd", addr_err_o, 0);
    cyc(0, 0, 0, 0, '0, 1, 14'h0043);
    chk("addr_err_3rd", addr_err_o, EXP_ERR);
    cyc(0, 1, 0, 0, '0, 0, '0);
    chk("zero_err", addr_err_o, 0);

    // Steady push+pop with two words resident
    salt = 9; base = 14'h0200; k = 0;
    cyc(0, 0, 1, 0, '0, 0, '0);
    drive(2, 1, 0);
    drive(20, 1, 1);
    cyc(0, 0, 1, 0, '0, 1, m_exp);
    drive(4, 0, 2);
    cyc(1, 0, 0, 0, '0, 0, '0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
